// File: rtl/addr8u_sched_pkg.sv
// Shared constants, state encoding and width helper for the redundant adder scheduler.
package addr8u_sched_pkg;

  localparam int OPW  = 8;
  localparam int SUMW = 9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS1 = 2'd1,
    PASS2 = 2'd2,
    RESP  = 2'd3
  } state_e;

  function automatic int idw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/addr8u_unit.sv
// Combinational 8-bit unsigned adder with full 9-bit result.
// Isolated so hardened adder variants can replace it without touching the sequencer.
module addr8u_unit
  import addr8u_sched_pkg::*;
(
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_b,
  output logic [SUMW-1:0] o_sum
);

  assign o_sum = {1'b0, i_a} + {1'b0, i_b};

endmodule

// File: rtl/addr8u_redund_sched.sv
// Round-robin scheduler sharing one adder; each sum is computed twice with swapped
// operands and compared, with bounded retry and a saturating error counter.
//
// state | meaning
// IDLE  | arbitrate, accept one request (req_ready) and capture its operands
// PASS1 | adder(A,B) -> s1
// PASS2 | adder(B,A) compared with s1; retry, or finish with/without error
// RESP  | response held until rsp_ready
module addr8u_redund_sched
  import addr8u_sched_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int MAX_RETRY = 2,
  localparam int IDW       = idw(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*OPW-1:0]  req_a,
  input  logic [NREQ*OPW-1:0]  req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [SUMW-1:0]      rsp_sum,
  output logic                 rsp_err,
  output logic [7:0]           err_cnt,
  output logic                 busy,
  input  logic [SUMW-1:0]      inj_mask
);

  state_e r_state;
  state_e w_state_nxt;

  logic [OPW-1:0]  r_a;
  logic [OPW-1:0]  r_b;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  r_rr_ptr;
  logic [2:0]      r_retry;
  logic [SUMW-1:0] r_s1;
  logic [SUMW-1:0] r_rsp_sum;
  logic [IDW-1:0]  r_rsp_id;
  logic            r_rsp_err;
  logic [7:0]      r_err_cnt;

  logic            w_hi_found;
  logic            w_lo_found;
  logic [IDW-1:0]  w_hi_idx;
  logic [IDW-1:0]  w_lo_idx;
  logic            w_found;
  logic [IDW-1:0]  w_grant;
  logic [OPW-1:0]  w_sel_a;
  logic [OPW-1:0]  w_sel_b;
  logic [OPW-1:0]  w_add_a;
  logic [OPW-1:0]  w_add_b;
  logic [SUMW-1:0] w_add_out;
  logic [SUMW-1:0] w_r2;
  logic            w_match;
  logic            w_can_retry;

  // Round robin: lowest valid index above the pointer wins, else lowest at/below it.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (IDW'(i) > r_rr_ptr) begin
          w_hi_found = 1'b1;
          w_hi_idx   = IDW'(i);
        end else begin
          w_lo_found = 1'b1;
          w_lo_idx   = IDW'(i);
        end
      end
    end
  end

  assign w_found = w_hi_found | w_lo_found;
  assign w_grant = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant == IDW'(i)) begin
        w_sel_a = req_a[i*OPW +: OPW];
        w_sel_b = req_b[i*OPW +: OPW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (r_state == IDLE && w_found) req_ready[w_grant] = 1'b1;
  end

  // Second pass swaps operands so a stuck adder input bit tends to show up as a mismatch.
  assign w_add_a = (r_state == PASS2) ? r_b : r_a;
  assign w_add_b = (r_state == PASS2) ? r_a : r_b;

  addr8u_unit u_unit (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .o_sum (w_add_out)
  );

  assign w_r2        = w_add_out ^ inj_mask;
  assign w_match     = (w_r2 == r_s1);
  assign w_can_retry = (r_retry < 3'(MAX_RETRY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found) w_state_nxt = PASS1;
      PASS1:   w_state_nxt = PASS2;
      PASS2: begin
        if (w_match)          w_state_nxt = RESP;
        else if (w_can_retry) w_state_nxt = PASS1;
        else                  w_state_nxt = RESP;
      end
      RESP:    if (rsp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_rr_ptr  <= IDW'(NREQ - 1);
      r_retry   <= '0;
      r_s1      <= '0;
      r_rsp_sum <= '0;
      r_rsp_id  <= '0;
      r_rsp_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_id     <= w_grant;
            r_rr_ptr <= w_grant;
            r_retry  <= '0;
          end
        end
        PASS1: r_s1 <= w_add_out;
        PASS2: begin
          if (w_match) begin
            r_rsp_sum <= r_s1;
            r_rsp_id  <= r_id;
            r_rsp_err <= 1'b0;
          end else if (w_can_retry) begin
            r_retry <= r_retry + 3'd1;
          end else begin
            r_rsp_sum <= r_s1;
            r_rsp_id  <= r_id;
            r_rsp_err <= 1'b1;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign busy      = (r_state != IDLE);
  assign rsp_id    = r_rsp_id;
  assign rsp_sum   = r_rsp_sum;
  assign rsp_err   = r_rsp_err;
  assign err_cnt   = r_err_cnt;

endmodule
